// File: rtl/npc_seq_unit.sv
// Next-PC sequencer: owns the architectural PC, resolves branch/jump/jr targets,
// handles stall, exception redirect and misaligned jr. Optional macro: NPC_DELAY_SLOT_EN.
module npc_seq_unit #(
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_3000,
    parameter logic [25:0] JMP_INDEX_BASE = 26'h000_0C00,
    parameter logic [31:0] EXC_VECTOR     = 32'h0000_4180,
    parameter int          CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic [2:0]           br_type,
    input  logic                 zero,
    input  logic                 cmp,
    input  logic [15:0]          br_imm,
    input  logic [25:0]          instr_index,
    input  logic                 jmp,
    input  logic                 jr,
    input  logic [31:0]          reg_target,
    input  logic                 exc_req,
    output logic [31:0]          pc,
    output logic [31:0]          pc_plus4,
    output logic                 redirect,
    output logic                 addr_err,
    output logic [CNT_WIDTH-1:0] taken_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        DELAY = 1'b1
    } state_t;

    state_t               state_reg, state_next;
    logic [31:0]          pc_reg, pc_next;
    logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
    logic                 addr_err_reg, addr_err_next;
`ifdef NPC_DELAY_SLOT_EN
    logic [31:0]          pending_reg, pending_next;
`endif

    logic        br_taken;
    logic        jr_misaligned;
    logic        transfer;
    logic [25:0] jmp_index;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic [31:0] xfer_target;

    // Branch relation for bgez/bgtz/blez/bltz is already folded into cmp by the ALU.
    always_comb begin
        br_taken = 1'b0;
        case (br_type)
            3'd1:                         br_taken = zero;
            3'd2:                         br_taken = ~zero;
            3'd3, 3'd4, 3'd5, 3'd6:       br_taken = cmp;
            default:                      br_taken = 1'b0;
        endcase
    end

    assign pc_plus4      = pc_reg + 32'd4;
    assign jmp_index     = instr_index + JMP_INDEX_BASE;
    assign br_target     = pc_reg + {{14{br_imm[15]}}, br_imm, 2'b00};
    assign jmp_target    = {pc_reg[31:28], jmp_index, 2'b00};
    assign jr_misaligned = jr && (reg_target[1:0] != 2'b00);
    assign transfer      = jr || jmp || br_taken;
    assign xfer_target   = jr  ? reg_target :
                           jmp ? jmp_target : br_target;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= RUN;
            pc_reg       <= RESET_VECTOR;
            cnt_reg      <= '0;
            addr_err_reg <= 1'b0;
`ifdef NPC_DELAY_SLOT_EN
            pending_reg  <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            cnt_reg      <= cnt_next;
            addr_err_reg <= addr_err_next;
`ifdef NPC_DELAY_SLOT_EN
            pending_reg  <= pending_next;
`endif
        end
    end

    // Next-state and datapath
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        cnt_next      = cnt_reg;
        addr_err_next = 1'b0;
`ifdef NPC_DELAY_SLOT_EN
        pending_next  = pending_reg;
`endif
        if (!stall) begin
            if (exc_req) begin
                pc_next    = EXC_VECTOR;
                state_next = RUN;
`ifdef NPC_DELAY_SLOT_EN
                pending_next = '0;
`endif
            end else if (state_reg == RUN) begin
                if (jr_misaligned) begin
                    pc_next       = EXC_VECTOR;
                    addr_err_next = 1'b1;
                end else if (transfer) begin
                    if (cnt_reg != {CNT_WIDTH{1'b1}})
                        cnt_next = cnt_reg + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
`ifdef NPC_DELAY_SLOT_EN
                    pending_next = xfer_target;
                    pc_next      = pc_plus4;
                    state_next   = DELAY;
`else
                    pc_next      = xfer_target;
`endif
                end else begin
                    pc_next = pc_plus4;
                end
            end else begin
                // Delay slot done: any transfer requested from the slot is discarded.
`ifdef NPC_DELAY_SLOT_EN
                pc_next      = pending_reg;
                pending_next = '0;
`else
                pc_next      = pc_plus4;
`endif
                state_next = RUN;
            end
        end
    end

    // Outputs
    always_comb begin
        redirect = 1'b0;
        if (!stall) begin
            if (exc_req)
                redirect = 1'b1;
            else if (state_reg == RUN)
                redirect = transfer;
        end
    end

    assign pc        = pc_reg;
    assign addr_err  = addr_err_reg;
    assign taken_cnt = cnt_reg;

endmodule

// File: tb/tb_npc_seq_unit.sv
// Directed self-checking bench for npc_seq_unit (default build, delay slot disabled).
module tb_npc_seq_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [2:0]  br_type;
    logic        zero;
    logic        cmp;
    logic [15:0] br_imm;
    logic [25:0] instr_index;
    logic        jmp;
    logic        jr;
    logic [31:0] reg_target;
    logic        exc_req;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic        addr_err;
    logic [15:0] taken_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    npc_seq_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .br_type     (br_type),
        .zero        (zero),
        .cmp         (cmp),
        .br_imm      (br_imm),
        .instr_index (instr_index),
        .jmp         (jmp),
        .jr          (jr),
        .reg_target  (reg_target),
        .exc_req     (exc_req),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .redirect    (redirect),
        .addr_err    (addr_err),
        .taken_cnt   (taken_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic clear_inputs();
        stall       = 1'b0;
        br_type     = 3'd0;
        zero        = 1'b0;
        cmp         = 1'b0;
        br_imm      = 16'h0000;
        instr_index = 26'h0;
        jmp         = 1'b0;
        jr          = 1'b0;
        reg_target  = 32'h0;
        exc_req     = 1'b0;
    endtask

    // Advance one clock edge and settle; inputs are then updated away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t pc=%h cnt=%0d addr_err=%b", $time, pc, taken_cnt, addr_err);
    endtask

    // Post-edge check of the registered outputs.
    task automatic chk_state(input string tag, input logic [31:0] exp_pc,
                             input logic [15:0] exp_cnt, input logic exp_aerr);
        chk({tag, "_pc"}, pc, exp_pc);
        chk({tag, "_cnt"}, {16'h0, taken_cnt}, {16'h0, exp_cnt});
        chk({tag, "_aerr"}, {31'h0, addr_err}, {31'h0, exp_aerr});
    endtask

    // Drive inputs, let them settle and check the combinational redirect.
    task automatic chk_redirect(input string tag, input logic exp_red);
        #1;
        chk({tag, "_redirect"}, {31'h0, redirect}, {31'h0, exp_red});
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk_state("reset", 32'h0000_3000, 16'd0, 1'b0);
        chk("reset_plus4", pc_plus4, 32'h0000_3004);
        chk_redirect("reset_idle", 1'b0);

        // Sequential fetch
        step(); chk_state("seq1", 32'h0000_3004, 16'd0, 1'b0);
        step(); chk_state("seq2", 32'h0000_3008, 16'd0, 1'b0);
        step(); chk_state("seq3", 32'h0000_300C, 16'd0, 1'b0);
        step(); chk_state("seq4", 32'h0000_3010, 16'd0, 1'b0);

        // beq taken: 0x3010 + 4*4 = 0x3020
        br_type = 3'd1; zero = 1'b1; br_imm = 16'h0004;
        chk_redirect("beq_taken", 1'b1);
        step(); clear_inputs();
        chk_state("beq_taken", 32'h0000_3020, 16'd1, 1'b0);

        // jr back to 0x3010, then beq not taken
        jr = 1'b1; reg_target = 32'h0000_3010;
        chk_redirect("jr_back", 1'b1);
        step(); clear_inputs();
        chk_state("jr_back", 32'h0000_3010, 16'd2, 1'b0);

        br_type = 3'd1; zero = 1'b0; br_imm = 16'h0004;
        chk_redirect("beq_not", 1'b0);
        step(); clear_inputs();
        chk_state("beq_not", 32'h0000_3014, 16'd2, 1'b0);

        // jmp: (0x10 + 0xC00) << 2 = 0x3040
        jmp = 1'b1; instr_index = 26'h10;
        chk_redirect("jmp", 1'b1);
        step(); clear_inputs();
        chk_state("jmp", 32'h0000_3040, 16'd3, 1'b0);

        // jr and jmp together: jr wins
        jmp = 1'b1; instr_index = 26'h10; jr = 1'b1; reg_target = 32'h0000_3100;
        chk_redirect("jr_wins", 1'b1);
        step(); clear_inputs();
        chk_state("jr_wins", 32'h0000_3100, 16'd4, 1'b0);

        // Misaligned jr: exception, one-cycle addr_err, no count
        jr = 1'b1; reg_target = 32'h0000_3102;
        chk_redirect("jr_misal", 1'b1);
        step(); clear_inputs();
        chk_state("jr_misal", 32'h0000_4180, 16'd4, 1'b1);
        step();
        chk_state("jr_misal_after", 32'h0000_4184, 16'd4, 1'b0);

        // bne taken (-2 words) held by stall for 3 cycles
        stall = 1'b1; br_type = 3'd2; zero = 1'b0; br_imm = 16'hFFFE;
        chk_redirect("stall", 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state("stall_hold", 32'h0000_4184, 16'd4, 1'b0);
            chk_redirect("stall_hold", 1'b0);
        end
        stall = 1'b0;
        chk_redirect("stall_release", 1'b1);
        step(); clear_inputs();
        chk_state("stall_release", 32'h0000_417C, 16'd5, 1'b0);

        // bgez with cmp=0 not taken; bltz with cmp=1 taken (+1 word)
        br_type = 3'd3; cmp = 1'b0; br_imm = 16'h0010;
        chk_redirect("bgez_not", 1'b0);
        step(); clear_inputs();
        chk_state("bgez_not", 32'h0000_4180, 16'd5, 1'b0);

        br_type = 3'd6; cmp = 1'b1; br_imm = 16'h0001;
        chk_redirect("bltz_taken", 1'b1);
        step(); clear_inputs();
        chk_state("bltz_taken", 32'h0000_4184, 16'd6, 1'b0);

        // Reserved br_type acts as none
        br_type = 3'd7; zero = 1'b1; cmp = 1'b1; br_imm = 16'h0040;
        chk_redirect("br_rsvd", 1'b0);
        step(); clear_inputs();
        chk_state("br_rsvd", 32'h0000_4188, 16'd6, 1'b0);

        // exc_req beats jr, counter unchanged
        exc_req = 1'b1; jr = 1'b1; reg_target = 32'h0000_3000;
        chk_redirect("exc", 1'b1);
        step(); clear_inputs();
        chk_state("exc", 32'h0000_4180, 16'd6, 1'b0);

        // exc_req beats misaligned jr: no addr_err
        exc_req = 1'b1; jr = 1'b1; reg_target = 32'h0000_3001;
        step(); clear_inputs();
        chk_state("exc_misal", 32'h0000_4180, 16'd6, 1'b0);

        // Sequential wrap past the top of the address space
        jr = 1'b1; reg_target = 32'hFFFF_FFFC;
        step(); clear_inputs();
        chk_state("wrap_jr", 32'hFFFF_FFFC, 16'd7, 1'b0);
        chk("wrap_plus4", pc_plus4, 32'h0000_0000);
        step();
        chk_state("wrap", 32'h0000_0000, 16'd7, 1'b0);

        // jmp keeps the upper pc nibble: pc=0xF0000000
        jr = 1'b1; reg_target = 32'hF000_0000;
        step(); clear_inputs();
        jmp = 1'b1; instr_index = 26'h3FF_F400;
        step(); clear_inputs();
        chk_state("jmp_hi", 32'hF000_0000, 16'd9, 1'b0);

        // Reset overrides stall
        rst = 1'b1; stall = 1'b1;
        step();
        rst = 1'b0; clear_inputs();
        chk_state("rst_stall", 32'h0000_3000, 16'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
